// File: rtl/nurn_step_sched.sv
// Time-step scheduler: turns the global tick into one timed neuron-controller step and flips the spike-buffer bank.
// Optional build macro SCHED_OVERRUN_CNT_EN adds a saturating 8-bit overrun counter on ovrCnt_o.
module nurn_step_sched #(
    parameter int NUM_NURNS        = 4,
    parameter int NUM_AXONS        = 4,
    parameter int LRN_DRAIN_CYCLES = 8,
    parameter int CYC_CNT_WIDTH    = 12,
    parameter int TICK_CNT_WIDTH   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      tick_i,
    input  logic                      clrMissed_i,
    output logic                      start_o,
    output logic                      busy_o,
    output logic                      stepDone_o,
    output logic                      spkBufSel_o,
    output logic                      tickPend_o,
    output logic                      tickMissed_o,
    output logic [TICK_CNT_WIDTH-1:0] tickCnt_o,
    output logic [7:0]                ovrCnt_o
);
    localparam int RCL_CYCLES = NUM_NURNS * (NUM_AXONS + 4);
    localparam logic [CYC_CNT_WIDTH-1:0] RCL_LOAD = CYC_CNT_WIDTH'(RCL_CYCLES - 1);
    localparam logic [CYC_CNT_WIDTH-1:0] DRN_LOAD = CYC_CNT_WIDTH'(LRN_DRAIN_CYCLES - 1);
    localparam logic [CYC_CNT_WIDTH-1:0] CYC_ONE  = CYC_CNT_WIDTH'(1);
    localparam logic [TICK_CNT_WIDTH-1:0] TICK_ONE = TICK_CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [CYC_CNT_WIDTH-1:0]  cyc_cnt_q, cyc_cnt_d;
    logic [TICK_CNT_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
    logic                      pend_q, pend_d;
    logic                      missed_q, missed_d;
    logic                      sel_q, sel_d;
    logic                      start_q, start_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      overrun;

    always_comb begin
        state_d    = state_q;
        cyc_cnt_d  = cyc_cnt_q;
        tick_cnt_d = tick_cnt_q;
        pend_d     = pend_q;
        sel_d      = sel_q;
        overrun    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (tick_i && en_i) state_d = S_START;
            end
            S_START: begin
                cyc_cnt_d = RCL_LOAD;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (cyc_cnt_q == '0) begin
                    cyc_cnt_d = DRN_LOAD;
                    state_d   = S_DRAIN;
                end else begin
                    cyc_cnt_d = cyc_cnt_q - CYC_ONE;
                end
            end
            S_DRAIN: begin
                if (cyc_cnt_q == '0) state_d = S_DONE;
                else                 cyc_cnt_d = cyc_cnt_q - CYC_ONE;
            end
            S_DONE: begin
                tick_cnt_d = tick_cnt_q + TICK_ONE;
                sel_d      = ~sel_q;
                pend_d     = 1'b0;
                state_d    = ((pend_q || tick_i) && en_i) ? S_START : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A tick during DONE is absorbed by the restart decision above, never an overrun.
        if (tick_i && (state_q inside {S_START, S_RUN, S_DRAIN})) begin
            if (pend_q) overrun = 1'b1;
            else        pend_d  = 1'b1;
        end

        missed_d = overrun ? 1'b1 : (clrMissed_i ? 1'b0 : missed_q);
        start_d  = (state_d == S_START);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cyc_cnt_q  <= '0;
            tick_cnt_q <= '0;
            pend_q     <= 1'b0;
            missed_q   <= 1'b0;
            sel_q      <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_cnt_q  <= cyc_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            pend_q     <= pend_d;
            missed_q   <= missed_d;
            sel_q      <= sel_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef SCHED_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    // Clear and a same-cycle overrun cancel out: the count holds.
    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (overrun && clrMissed_i)    ovr_cnt_d = ovr_cnt_q;
        else if (clrMissed_i)          ovr_cnt_d = '0;
        else if (overrun && (ovr_cnt_q != 8'hFF)) ovr_cnt_d = ovr_cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ovr_cnt_q <= '0;
        else       ovr_cnt_q <= ovr_cnt_d;
    end

    assign ovrCnt_o = ovr_cnt_q;
`else
    assign ovrCnt_o = '0;
`endif

    assign start_o      = start_q;
    assign busy_o       = busy_q;
    assign stepDone_o   = done_q;
    assign spkBufSel_o  = sel_q;
    assign tickPend_o   = pend_q;
    assign tickMissed_o = missed_q;
    assign tickCnt_o    = tick_cnt_q;

endmodule
